// File: rtl/pio_sched_pkg.sv
// rtl/pio_sched_pkg.sv - shared types and constants for the PIO command scheduler
package pio_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_t;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_GAP    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_FULL_BIT  = 5;
  localparam int STAT_EMPTY_BIT = 6;
  localparam int STAT_OVF_BIT   = 7;
  localparam int STAT_RPL_BIT   = 8;
  localparam int STAT_STATE_LSB = 9;

endpackage

// File: rtl/pio_cmd_fifo.sv
// rtl/pio_cmd_fifo.sv - command FIFO with flush; a push into a full FIFO is taken only alongside a pop
module pio_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [4:0]   count,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == 5'd0);
  assign head  = mem[rd_ptr];

  // Flush overrides everything in its cycle, including a coincident push.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign drop    = push && !flush && full && !do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {4'd0, do_push} - {4'd0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pio_cmd_scheduler.sv
// rtl/pio_cmd_scheduler.sv - Avalon-MM command queue issuing paced write pulses, with key-triggered replay
module pio_cmd_scheduler
  import pio_sched_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] GAP_RESET = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [1:0]  key,
  output logic        core_write,
  output logic [31:0] core_writedata
);

  sched_state_t state_q, state_d;
  logic [15:0]  gap_q, cnt_q, cnt_d;
  logic         enable_q, flush_q, overflow_q, replay_q, issued_q;
  logic [31:0]  last_q;
  logic [1:0]   key_sync;
  logic         key_d;

  logic [31:0]  head;
  logic [4:0]   count;
  logic         full, empty, drop;
  logic         push, pop, go, issuing, key_fall;
  logic [31:0]  issue_word;
  logic [31:0]  status;
  logic         unused_key;

  assign unused_key = key[1];

  assign push     = write && (address == ADDR_CMD);
  assign issuing  = (state_q == ST_ISSUE);
  assign pop      = issuing && !empty;
  assign go       = enable_q && !flush_q && (!empty || replay_q);
  assign key_fall = key_d && !key_sync[1];

  // Queued commands take priority; an empty FIFO in ISSUE means a replay.
  assign issue_word     = empty ? last_q : head;
  assign core_write     = issuing;
  assign core_writedata = issuing ? issue_word : last_q;

  pio_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (writedata),
    .pop       (pop),
    .flush     (flush_q),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop      (drop)
  );

  always_comb begin
    status = 32'd0;
    status[STAT_COUNT_LSB +: 5] = count;
    status[STAT_FULL_BIT]       = full;
    status[STAT_EMPTY_BIT]      = empty;
    status[STAT_OVF_BIT]        = overflow_q;
    status[STAT_RPL_BIT]        = replay_q;
    status[STAT_STATE_LSB +: 2] = state_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = (gap_q == 16'd0) ? 16'd1 : gap_q;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = go ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      gap_q      <= GAP_RESET;
      enable_q   <= 1'b0;
      flush_q    <= 1'b0;
      overflow_q <= 1'b0;
      replay_q   <= 1'b0;
      issued_q   <= 1'b0;
      last_q     <= 32'd0;
      key_sync   <= 2'b11;
      key_d      <= 1'b1;
      readdata   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_sync <= {key_sync[0], key[0]};
      key_d    <= key_sync[1];
      // Flush is a one-cycle pulse acting in the cycle after the ctrl write.
      flush_q  <= write && (address == ADDR_CTRL) && writedata[1];

      if (write && address == ADDR_GAP)  gap_q    <= writedata[15:0];
      if (write && address == ADDR_CTRL) enable_q <= writedata[0];

      if (drop)
        overflow_q <= 1'b1;
      else if (write && address == ADDR_STATUS && writedata[0])
        overflow_q <= 1'b0;

      if (issuing) begin
        last_q   <= issue_word;
        issued_q <= 1'b1;
      end

      // A key press before anything was issued has nothing to replay.
      if (flush_q)
        replay_q <= 1'b0;
      else if (key_fall && issued_q)
        replay_q <= 1'b1;
      else if (issuing && empty)
        replay_q <= 1'b0;

      if (read) begin
        case (address)
          ADDR_CMD:    readdata <= last_q;
          ADDR_STATUS: readdata <= status;
          ADDR_GAP:    readdata <= {16'd0, gap_q};
          default:     readdata <= {30'd0, flush_q, enable_q};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_cmd_scheduler.sv
// tb/tb_pio_cmd_scheduler.sv - directed and randomized checks of pio_cmd_scheduler against a queue-based model
module tb_pio_cmd_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [1:0]  key = 2'b11;
  logic        core_write;
  logic [31:0] core_writedata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int          pc[$];
  logic [31:0] pd[$];
  logic [31:0] exp_q[$];

  pio_cmd_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .read           (read),
    .readdata       (readdata),
    .write          (write),
    .writedata      (writedata),
    .key            (key),
    .core_write     (core_write),
    .core_writedata (core_writedata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && core_write) begin
      pc.push_back(cyc);
      pd.push_back(core_writedata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_press(input int n);
    @(negedge clk);
    key = 2'b10;
    idle(n);
    key = 2'b11;
  endtask

  // Expected status word from the documented bit layout.
  function automatic logic [31:0] stat(input int cnt, input bit ovf, input bit rp, input int st);
    return 32'(cnt) | ((cnt == DEPTH) ? 32'h20 : 32'h0) | ((cnt == 0) ? 32'h40 : 32'h0)
         | (ovf ? 32'h80 : 32'h0) | (rp ? 32'h100 : 32'h0) | 32'(st << 9);
  endfunction

  task automatic check_pulses(input string tag, input int spacing);
    chk({tag, "_count"}, 32'(pc.size()), 32'(exp_q.size()));
    for (int i = 0; i < pc.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), pd[i], exp_q[i]);
      if (i > 0) chk($sformatf("%s_space%0d", tag, i), 32'(pc[i] - pc[i-1]), 32'(spacing));
    end
    pc.delete();
    pd.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] w [8];
    int n, g, gm, kept;
    bit found;

    idle(3);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_core_write", {31'd0, core_write}, 32'd0);
    chk("rst_core_wdata", core_writedata, 32'd0);
    reset = 1'b0;
    bus_read(2'd1, rd); chk("rst_status", rd, stat(0, 0, 0, 0));
    bus_read(2'd2, rd); chk("rst_gap", rd, 32'd1000);
    bus_read(2'd3, rd); chk("rst_ctrl", rd, 32'd0);
    bus_read(2'd0, rd); chk("rst_last", rd, 32'd0);

    // Key press before any issue is discarded.
    bus_write(2'd3, 32'd1);
    key_press(10);
    idle(6);
    bus_read(2'd1, rd); chk("noissue_status", rd, stat(0, 0, 0, 0));
    check_pulses("noissue", 0);

    // Two commands at gap 3.
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h00018005);
    bus_write(2'd0, 32'h00030002);
    idle(20);
    exp_q = '{32'h00018005, 32'h00030002};
    check_pulses("two_cmds", 4);
    bus_write(2'd3, 32'd0);
    bus_read(2'd1, rd); chk("two_cmds_status", rd, stat(0, 0, 0, 0));

    // Single replay of the last issued word.
    bus_write(2'd2, 32'd2);
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'h12345678);
    idle(10);
    exp_q = '{32'h12345678};
    check_pulses("seed", 3);
    key_press(10);
    idle(15);
    exp_q = '{32'h12345678};
    check_pulses("replay", 3);
    bus_read(2'd0, rd); chk("replay_last", rd, 32'h12345678);

    // FIFO word beats a pending replay.
    bus_write(2'd3, 32'd0);
    bus_write(2'd2, 32'd3);
    key_press(6);
    idle(5);
    bus_read(2'd1, rd); chk("prio_pending", rd, stat(0, 0, 1, 0));
    bus_write(2'd0, 32'hA5A50001);
    bus_read(2'd1, rd); chk("prio_queued", rd, stat(1, 0, 1, 0));
    bus_write(2'd3, 32'd1);
    idle(20);
    exp_q = '{32'hA5A50001, 32'hA5A50001};
    check_pulses("prio", 4);
    bus_write(2'd3, 32'd0);
    bus_read(2'd1, rd); chk("prio_status", rd, stat(0, 0, 0, 0));

    // Randomized fill/overflow/drain trials; trial 0 is the five-push overflow case.
    for (int t = 0; t < 6; t++) begin
      n = (t == 0) ? 5 : $urandom_range(1, 7);
      g = $urandom_range(0, 5);
      gm = (g == 0) ? 1 : g;
      kept = (n > DEPTH) ? DEPTH : n;
      bus_write(2'd2, 32'(g));
      for (int i = 0; i < n; i++) begin
        w[i] = $urandom;
        bus_write(2'd0, w[i]);
        if (i < DEPTH) exp_q.push_back(w[i]);
      end
      bus_read(2'd1, rd); chk($sformatf("t%0d_fill", t), rd, stat(kept, n > DEPTH, 0, 0));
      if (n > DEPTH) begin
        bus_write(2'd1, 32'd1);
        bus_read(2'd1, rd); chk($sformatf("t%0d_ovfclr", t), rd, stat(kept, 0, 0, 0));
      end
      bus_write(2'd3, 32'd1);
      idle((gm + 1) * 5 + 10);
      bus_write(2'd3, 32'd0);
      check_pulses($sformatf("t%0d", t), gm + 1);
      bus_read(2'd1, rd); chk($sformatf("t%0d_drained", t), rd, stat(0, 0, 0, 0));
      bus_read(2'd0, rd); chk($sformatf("t%0d_last", t), rd, w[kept-1]);
    end

    // Gap 0 spaces pulses two cycles apart.
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'hC0000001);
    bus_write(2'd0, 32'hC0000002);
    bus_write(2'd0, 32'hC0000003);
    bus_write(2'd3, 32'd1);
    idle(15);
    exp_q = '{32'hC0000001, 32'hC0000002, 32'hC0000003};
    check_pulses("gap0", 2);
    bus_write(2'd3, 32'd0);

    // Flush with a push landing in the flush cycle, FIFO full beforehand.
    for (int i = 0; i < DEPTH; i++) bus_write(2'd0, 32'hF0000000 + 32'(i));
    bus_read(2'd1, rd); chk("flush_pre", rd, stat(DEPTH, 0, 0, 0));
    bus_write(2'd3, 32'd2);
    bus_write(2'd0, 32'hDEAD0000);
    bus_read(2'd1, rd); chk("flush_post", rd, stat(0, 0, 0, 0));
    bus_read(2'd3, rd); chk("flush_selfclr", rd, 32'd0);

    // Reset during WAIT with two words queued.
    bus_write(2'd2, 32'd10);
    bus_write(2'd0, 32'h10000001);
    bus_write(2'd0, 32'h10000002);
    bus_write(2'd0, 32'h10000003);
    bus_write(2'd3, 32'd1);
    for (int i = 0; i < 50 && pc.size() == 0; i++) @(negedge clk);
    chk("wait_first_pulse", 32'(pc.size()), 32'd1);
    idle(3);
    bus_read(2'd1, rd); chk("wait_status", rd, stat(2, 0, 0, 2));
    reset = 1'b1;
    #1;
    chk("wrst_core_write", {31'd0, core_write}, 32'd0);
    chk("wrst_core_wdata", core_writedata, 32'd0);
    chk("wrst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pc.delete();
    pd.delete();
    bus_read(2'd1, rd); chk("wrst_status", rd, stat(0, 0, 0, 0));
    bus_read(2'd2, rd); chk("wrst_gap", rd, 32'd1000);
    idle(3);
    chk("wrst_hold", readdata, 32'd1000);
    bus_read(2'd3, rd); chk("wrst_ctrl", rd, 32'd0);
    bus_read(2'd0, rd); chk("wrst_last", rd, 32'd0);
    idle(30);
    check_pulses("wrst_none", 0);

    // Reset asserted inside the ISSUE cycle drops core_write at once.
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h0BADF00D);
    bus_write(2'd3, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (core_write) found = 1'b1;
    end
    chk("irst_found", {31'd0, found}, 32'd1);
    reset = 1'b1;
    #1;
    chk("irst_core_write", {31'd0, core_write}, 32'd0);
    chk("irst_core_wdata", core_writedata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pc.delete();
    pd.delete();
    idle(20);
    check_pulses("irst_none", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_cmd_scheduler.md
PIO_CMD_SCHEDULER -- requirements
Module: pio_cmd_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth, power of two, 2..16.
REQ-002 Parameter GAP_RESET, default 1000: reset value of the 16-bit gap register.
REQ-003 Port clk  in  1: single clock; all logic on rising edge.
REQ-004 Port reset  in  1: asynchronous, active-high reset.
REQ-005 Port address  in  2: Avalon-MM slave word address.
REQ-006 Port read  in  1: Avalon read strobe.
REQ-007 Port readdata  out  32: registered read data.
REQ-008 Port write  in  1: Avalon write strobe.
REQ-009 Port writedata  in  32: Avalon write data; command format [31:15] pattern, [7:0] user.
REQ-010 Port key  in  2: raw board keys, active-low; key[0] = replay request, key[1] unused.
REQ-011 Port core_write  out  1: one-cycle write strobe to game datapath.
REQ-012 Port core_writedata  out  32: command word presented with core_write.

Function
REQ-013 Register map SHALL be: addr0 W = push command / R = last issued word; addr1 R = status / W bit0=1 clears overflow; addr2 RW = gap[15:0]; addr3 RW = ctrl (bit0 enable, bit1 flush).
REQ-014 readdata SHALL update one cycle after a read strobe; other cycles hold value; unmapped bits read 0.
REQ-015 Status SHALL be: [4:0] fill count, [5] full, [6] empty, [7] overflow sticky, [8] replay_pending, [10:9] FSM state.
REQ-016 Push SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs the same cycle; otherwise the word is dropped and overflow set.
REQ-017 key[0] SHALL pass a 2-FF synchronizer; a synchronized 1->0 edge sets replay_pending; held key sets it once.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-019 IDLE -> ISSUE when enable=1 and (FIFO not empty or replay_pending).
REQ-020 ISSUE SHALL last one cycle: core_write=1; FIFO head popped if non-empty, else last word replayed and replay_pending cleared; FIFO wins over replay.
REQ-021 ISSUE SHALL record the issued word as last word, load gap counter with max(gap,1), go to WAIT.
REQ-022 WAIT SHALL decrement the counter; at counter==1 go to ISSUE if the IDLE condition holds, else IDLE; consecutive pulses thus spaced exactly max(gap,1)+1 cycles.
REQ-023 replay_pending SHALL be discarded (cleared) if no word has been issued since reset.
REQ-024 Flush SHALL self-clear, empty the FIFO and clear replay_pending in one cycle; a push in the same cycle is discarded without setting overflow.
REQ-025 Flush or enable=0 during ISSUE/WAIT SHALL not truncate the current pulse or wait.
REQ-026 core_writedata SHALL hold the last issued word when core_write=0.

Reset
REQ-027 Reset SHALL give: state IDLE, FIFO empty, overflow 0, replay_pending 0, last word 0, gap=GAP_RESET, enable 0, core_write 0, core_writedata 0, readdata 0, synchronizer stages 1.
REQ-028 Reset asserted mid-ISSUE SHALL force core_write low immediately (asynchronously).

Structure
REQ-029 Package pio_sched_pkg SHALL hold the state enum, address constants and status bit positions.
REQ-030 FIFO SHALL be sub-module pio_cmd_fifo (push/pop/flush, count, full, empty).

Verification
REQ-031 enable=1, gap=3, push 0x00018005 and 0x00030002 -> two core_write pulses 4 cycles apart, data in push order.
REQ-032 enable=0, push 5 words (DEPTH=4) -> status count=4, full=1, overflow=1; write addr1=1 -> overflow=0.
REQ-033 After one issue of 0x12345678, key[0] low for 10 cycles -> exactly one replay pulse with 0x12345678.
REQ-034 Replay pending and FIFO non-empty together -> FIFO word issued first, replay next after gap+1 cycles.
REQ-035 gap=0, 3 words queued -> pulses every 2 cycles; flush + push in same cycle -> FIFO empty, overflow 0.
REQ-036 Reset during WAIT with 2 words queued -> all REQ-027 values next cycle, no further core_write.
